ceas_alarma: RTL and testbench
==============================

// Module: ceas_alarma
// PURPOSE
//  Time-keeping and alarm datapath fed by control_top's mode/increment strobes.
//  Keeps HH:MM:SS from a divided 1 Hz tick and holds an alarm HH:MM set through the same strobes.
//  Drives suna (buzzer request) when the alarm is armed and matches.
//  Sits directly downstream of the button/mode controller; upstream of display mux.
// PARAMETERS
//  TICK_DIV    50_000_000  clock cycles per second tick (>=2)
//  RING_SEC    60          max seconds suna stays high without stop
//  SNOOZE_SEC  300         seconds to re-ring after snooze (CEAS_SNOOZE_EN only)
// PORTS
//  clock            in   1  single system clock, all logic on posedge
//  reset            in   1  asynchronous, active-low reset (0 = reset asserted)
//  semnal_setare    in   1  time-set mode level
//  semnal_setare_a  in   1  alarm-set mode level
//  semnal_stop      in   1  stop/disarm request
//  semnal_b1        in   1  hours increment request (also snooze, see CONFIGURATION)
//  semnal_b2        in   1  minutes increment request
//  ore              out  5  current hours 0..23
//  minute           out  6  current minutes 0..59
//  secunde          out  6  current seconds 0..59
//  al_ore           out  5  alarm hours 0..23
//  al_minute        out  6  alarm minutes 0..59
//  armat            out  1  alarm armed
//  suna             out  1  alarm ringing
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, divider 0, edge regs 0, ring/snooze counters 0.
//  Divider: counts 0..TICK_DIV-1; tick = (cnt==TICK_DIV-1); cnt wraps to 0.
//  Inputs b1/b2/stop are rising-edge detected internally (1-cycle pulse); input held high = one event.
//  Increment is visible right after the clock edge that sees input=1 with previous sample 0.
//  Priority of modes: semnal_setare > semnal_setare_a > normal run.
//  RUN (no set mode): on tick secunde+1; 59->0 carries minute; 59->0 carries ore; 23->0.
//  SET_TIME (semnal_setare=1): counting frozen, secunde forced 0, divider held at 0;
//    b1 edge: ore+1 (23->0, no carry); b2 edge: minute+1 (59->0, no carry to ore).
//    b1 and b2 edges in same cycle: both applied.
//  SET_ALARM (semnal_setare_a=1): time keeps running; b1/b2 edit al_ore/al_minute same wrap rules;
//    falling edge of semnal_setare_a sets armat=1.
//  Match: in RUN, on the tick edge whose new value is al_ore:al_minute:00 and armat=1 -> suna=1.
//    No match evaluated while either set mode is high (a skipped :00 is not replayed).
//  Ringing: ring counter counts ticks; suna clears after RING_SEC ticks, armat stays 1 (rings next day).
//  stop edge while suna=1: suna=0, armat stays 1. stop edge while suna=0: armat=0.
//  Entering SET_TIME or SET_ALARM while suna=1: suna=0 immediately (next edge).
//  Reset mid-ring or mid-set: full return to reset values; alarm setting lost.
// CONFIGURATION
//  CEAS_SNOOZE_EN defined: b1 edge while suna=1 (RUN) -> suna=0, snooze counter loaded
//    with SNOOZE_SEC, decremented per tick; at 0 -> suna=1 again (new RING_SEC window);
//    stop edge or any set mode cancels pending snooze.
//  CEAS_SNOOZE_EN undefined: b1 ignored in RUN; no snooze counter synthesized.
// STRUCTURE
//  Package ceas_pkg (ceas_pkg.vh): MAX_ORE=23, MAX_MIN=59, MAX_SEC=59, field widths,
//    mode encodings M_RUN/M_SET/M_SETA.
//  Sub-module divizor_secunda: parameter TICK_DIV, ports clock/reset/hold/tick.
//  Remaining logic (edge detect, counters, alarm FSM IDLE/RING/SNOOZE) in this module.
// TESTING  (TICK_DIV=4, RING_SEC=3, SNOOZE_SEC=2)
//  Reset low mid-run -> all outputs 0 asynchronously, before next clock edge.
//  Run 23:59:59 + one tick -> 00:00:00, no spurious carry.
//  setare=1, b1 pulsed 25 times -> ore=1; b2 held high 10 cycles -> minute+1 only.
//  setare_a: set 00:01, release -> armat=1; time reaches 00:01:00 -> suna=1 on that tick edge,
//    clears after 3 ticks, armat still 1.
//  suna=1, stop edge -> suna=0, armat=1; second stop edge -> armat=0, no ring at next match.
//  CEAS_SNOOZE_EN: suna=1, b1 edge -> suna=0, suna=1 again after 2 ticks; without macro b1 no effect.

Source files
------------

// File: rtl/ceas_alarma_pkg.sv
// rtl/ceas_alarma_pkg.sv - shared limits, field widths, mode/state encodings and wrap helpers
package ceas_alarma_pkg;

  localparam int W_ORE = 5;
  localparam int W_MIN = 6;
  localparam int W_SEC = 6;

  localparam logic [W_ORE-1:0] MAX_ORE = 5'd23;
  localparam logic [W_MIN-1:0] MAX_MIN = 6'd59;
  localparam logic [W_SEC-1:0] MAX_SEC = 6'd59;

  typedef enum logic [1:0] {M_RUN, M_SET, M_SETA} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} alarm_state_t;

  // hours step 23 -> 0
  function automatic logic [W_ORE-1:0] inc_ore(input logic [W_ORE-1:0] v);
    return (v == MAX_ORE) ? '0 : v + 1'b1;
  endfunction

  // minutes/seconds step max -> 0
  function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] maxv);
    return (v == maxv) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/ceas_alarma_if.sv
// rtl/ceas_alarma_if.sv - controller strobes in, time/alarm state out
interface ceas_alarma_if;
  import ceas_alarma_pkg::*;

  logic             semnal_setare;
  logic             semnal_setare_a;
  logic             semnal_stop;
  logic             semnal_b1;
  logic             semnal_b2;
  logic [W_ORE-1:0] ore;
  logic [W_MIN-1:0] minute;
  logic [W_SEC-1:0] secunde;
  logic [W_ORE-1:0] al_ore;
  logic [W_MIN-1:0] al_minute;
  logic             armat;
  logic             suna;

  modport master (
    output semnal_setare, semnal_setare_a, semnal_stop, semnal_b1, semnal_b2,
    input  ore, minute, secunde, al_ore, al_minute, armat, suna
  );

  modport slave (
    input  semnal_setare, semnal_setare_a, semnal_stop, semnal_b1, semnal_b2,
    output ore, minute, secunde, al_ore, al_minute, armat, suna
  );
endinterface

// File: rtl/ceas_alarma_divizor_secunda.sv
// rtl/ceas_alarma_divizor_secunda.sv - one-cycle tick every TICK_DIV clocks, held at 0 by hold
module divizor_secunda #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = !hold && (cnt == CW'(TICK_DIV - 1));

  // free-running 0..TICK_DIV-1 counter, parked at 0 while time is being set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (hold || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/ceas_alarma.sv
// rtl/ceas_alarma.sv - clock/alarm datapath with ring FSM; CEAS_SNOOZE_EN adds b1 snooze
module ceas_alarma
  import ceas_alarma_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic          clock,
  input  logic          reset,
  ceas_alarma_if.slave  bus
);
  localparam int RW = $clog2(RING_SEC + 1);

  mode_t            mode;
  alarm_state_t     state;
  logic             tick, hold;
  logic             b1_q, b2_q, stop_q, seta_q;
  logic             b1_e, b2_e, stop_e, seta_fall;
  logic [W_ORE-1:0] ore_q, al_ore_q, nxt_ore;
  logic [W_MIN-1:0] min_q, al_min_q, nxt_min;
  logic [W_SEC-1:0] sec_q, nxt_sec;
  logic             armat_q, suna_q, alarm_hit;
  logic [RW-1:0]    ring_cnt;
`ifdef CEAS_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  logic [SW-1:0]    snz_cnt;
`endif

  // set-time wins over set-alarm, which wins over normal running
  always_comb begin
    mode = M_RUN;
    if (bus.semnal_setare) mode = M_SET;
    else if (bus.semnal_setare_a) mode = M_SETA;
  end

  assign hold = (mode == M_SET);

  divizor_secunda #(.TICK_DIV(TICK_DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .hold  (hold),
    .tick  (tick)
  );

  // previous samples for rising-edge detection of the button strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b1_q   <= 1'b0;
      b2_q   <= 1'b0;
      stop_q <= 1'b0;
      seta_q <= 1'b0;
    end else begin
      b1_q   <= bus.semnal_b1;
      b2_q   <= bus.semnal_b2;
      stop_q <= bus.semnal_stop;
      seta_q <= bus.semnal_setare_a;
    end
  end

  assign b1_e      = bus.semnal_b1 & ~b1_q;
  assign b2_e      = bus.semnal_b2 & ~b2_q;
  assign stop_e    = bus.semnal_stop & ~stop_q;
  assign seta_fall = seta_q & ~bus.semnal_setare_a;

  // time value after one second, with carries into minutes and hours
  always_comb begin
    nxt_sec = inc_wrap6(sec_q, MAX_SEC);
    nxt_min = min_q;
    nxt_ore = ore_q;
    if (sec_q == MAX_SEC) begin
      nxt_min = inc_wrap6(min_q, MAX_MIN);
      if (min_q == MAX_MIN) nxt_ore = inc_ore(ore_q);
    end
  end

  assign alarm_hit = (nxt_sec == '0) && (nxt_min == al_min_q) && (nxt_ore == al_ore_q);

  // time of day: manual edit without carry in set mode, ticking otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ore_q <= '0;
      min_q <= '0;
      sec_q <= '0;
    end else if (mode == M_SET) begin
      sec_q <= '0;
      if (b1_e) ore_q <= inc_ore(ore_q);
      if (b2_e) min_q <= inc_wrap6(min_q, MAX_MIN);
    end else if (tick) begin
      sec_q <= nxt_sec;
      min_q <= nxt_min;
      ore_q <= nxt_ore;
    end
  end

  // alarm time edited only in set-alarm mode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      al_ore_q <= '0;
      al_min_q <= '0;
    end else if (mode == M_SETA) begin
      if (b1_e) al_ore_q <= inc_ore(al_ore_q);
      if (b2_e) al_min_q <= inc_wrap6(al_min_q, MAX_MIN);
    end
  end

  // arm/disarm plus IDLE/RING/SNOOZE ringing control; matches only checked while running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      armat_q  <= 1'b0;
      suna_q   <= 1'b0;
      ring_cnt <= '0;
`ifdef CEAS_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      if (stop_e && !suna_q) armat_q <= 1'b0;
      if (seta_fall) armat_q <= 1'b1;
      if (mode != M_RUN) begin
        state    <= S_IDLE;
        suna_q   <= 1'b0;
        ring_cnt <= '0;
      end else begin
        case (state)
          S_RING: begin
            if (stop_e) begin
              state  <= S_IDLE;
              suna_q <= 1'b0;
            end
`ifdef CEAS_SNOOZE_EN
            else if (b1_e) begin
              state   <= S_SNOOZE;
              suna_q  <= 1'b0;
              snz_cnt <= SW'(SNOOZE_SEC);
            end
`endif
            else if (tick) begin
              if (ring_cnt == RW'(RING_SEC - 1)) begin
                state  <= S_IDLE;
                suna_q <= 1'b0;
              end else begin
                ring_cnt <= ring_cnt + 1'b1;
              end
            end
          end
`ifdef CEAS_SNOOZE_EN
          S_SNOOZE: begin
            if (stop_e) state <= S_IDLE;
            else if (tick) begin
              if (snz_cnt <= SW'(1)) begin
                state    <= S_RING;
                suna_q   <= 1'b1;
                ring_cnt <= '0;
              end else begin
                snz_cnt <= snz_cnt - 1'b1;
              end
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
        if (tick && armat_q && alarm_hit) begin
          state    <= S_RING;
          suna_q   <= 1'b1;
          ring_cnt <= '0;
        end
      end
    end
  end

  assign bus.ore       = ore_q;
  assign bus.minute    = min_q;
  assign bus.secunde   = sec_q;
  assign bus.al_ore    = al_ore_q;
  assign bus.al_minute = al_min_q;
  assign bus.armat     = armat_q;
  assign bus.suna      = suna_q;
endmodule

// File: tb/tb_ceas_alarma.sv
// tb/tb_ceas_alarma.sv - scoreboard bench for ceas_alarma (TICK_DIV=4, RING_SEC=3, SNOOZE_SEC=2)
module tb_ceas_alarma;

  typedef struct {
    string       name;
    logic [29:0] exp;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clock = ~clock;

  ceas_alarma_if bus();

  ceas_alarma #(.TICK_DIV(4), .RING_SEC(3), .SNOOZE_SEC(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [29:0] pack(int h, int m, int s, int ah, int am, bit arm, bit sn);
    return {5'(h), 6'(m), 6'(s), 5'(ah), 6'(am), arm, sn};
  endfunction

  function automatic string fmt(logic [29:0] v);
    return $sformatf("%0d:%0d:%0d al=%0d:%0d armat=%0b suna=%0b",
                     v[29:25], v[24:19], v[18:13], v[12:8], v[7:2], v[1], v[0]);
  endfunction

  initial begin
    exp_t        e;
    logic [29:0] act;
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.ore, bus.minute, bus.secunde, bus.al_ore, bus.al_minute, bus.armat, bus.suna};
        n_total++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %s required %s", e.name, fmt(act), fmt(e.exp));
      end
    end
  end

  initial begin
    #500000;
    if (n_pass != n_total)
      $display("FAIL watchdog: %0d/%0d checks passed before timeout", n_pass, n_total);
    else
      $display("FAIL watchdog: stimulus did not complete, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1);
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ticks(int n);
    cyc(4 * n);
  endtask

  task automatic expect_st(string nm, int h, int m, int s, int ah, int am, bit arm, bit sn);
    exp_t e;
    e.name = nm;
    e.exp  = pack(h, m, s, ah, am, arm, sn);
    sb.push_back(e);
    @(negedge clock);
    #1;
  endtask

  task automatic check_now(string nm, int h, int m, int s, int ah, int am, bit arm, bit sn);
    logic [29:0] act;
    logic [29:0] req;
    act = {bus.ore, bus.minute, bus.secunde, bus.al_ore, bus.al_minute, bus.armat, bus.suna};
    req = pack(h, m, s, ah, am, arm, sn);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %s required %s", nm, fmt(act), fmt(req));
  endtask

  task automatic pulse_b1;
    bus.semnal_b1 = 1'b1; cyc(1);
    bus.semnal_b1 = 1'b0; cyc(1);
  endtask

  task automatic pulse_b2;
    bus.semnal_b2 = 1'b1; cyc(1);
    bus.semnal_b2 = 1'b0; cyc(1);
  endtask

  task automatic pulse_stop;
    bus.semnal_stop = 1'b1; cyc(1);
    bus.semnal_stop = 1'b0; cyc(3);
  endtask

  initial begin
    reset               = 1'b0;
    bus.semnal_setare   = 1'b0;
    bus.semnal_setare_a = 1'b0;
    bus.semnal_stop     = 1'b0;
    bus.semnal_b1       = 1'b0;
    bus.semnal_b2       = 1'b0;
    cyc(2);
    expect_st("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    ticks(2);
    expect_st("run_2s", 0, 0, 2, 0, 0, 0, 0);

    // reset dropped between edges must clear outputs before any clock edge
    cyc(1);
    reset = 1'b0;
    #1;
    check_now("async_rst_now", 0, 0, 0, 0, 0, 0, 0);
    expect_st("async_rst", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    bus.semnal_setare = 1'b1;
    for (int i = 0; i < 25; i++) pulse_b1();
    expect_st("set_b1_wrap", 1, 0, 0, 0, 0, 0, 0);
    bus.semnal_b2 = 1'b1; cyc(10);
    bus.semnal_b2 = 1'b0; cyc(1);
    expect_st("set_b2_held", 1, 1, 0, 0, 0, 0, 0);
    bus.semnal_b1 = 1'b1; bus.semnal_b2 = 1'b1; cyc(1);
    bus.semnal_b1 = 1'b0; bus.semnal_b2 = 1'b0; cyc(1);
    expect_st("set_both", 2, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      bus.semnal_b1 = 1'b1; bus.semnal_b2 = 1'b1; cyc(1);
      bus.semnal_b1 = 1'b0; bus.semnal_b2 = 1'b0; cyc(1);
    end
    for (int i = 0; i < 36; i++) pulse_b2();
    expect_st("set_2359", 23, 59, 0, 0, 0, 0, 0);

    bus.semnal_setare = 1'b0;
    ticks(59);
    expect_st("run_59s", 23, 59, 59, 0, 0, 0, 0);
    ticks(1);
    expect_st("day_wrap", 0, 0, 0, 0, 0, 0, 0);

    bus.semnal_setare_a = 1'b1;
    pulse_b2();
    cyc(2);
    expect_st("seta_edit", 0, 0, 1, 0, 1, 0, 0);
    bus.semnal_setare_a = 1'b0;
    cyc(4);
    expect_st("armed", 0, 0, 2, 0, 1, 1, 0);

    ticks(57);
    expect_st("pre_match", 0, 0, 59, 0, 1, 1, 0);
    ticks(1);
    expect_st("match_ring", 0, 1, 0, 0, 1, 1, 1);
    ticks(2);
    expect_st("ring_hold", 0, 1, 2, 0, 1, 1, 1);
    ticks(1);
    expect_st("ring_timeout", 0, 1, 3, 0, 1, 1, 0);

    bus.semnal_setare_a = 1'b1;
    pulse_b2();
    cyc(2);
    bus.semnal_setare_a = 1'b0;
    cyc(4);
    expect_st("rearm", 0, 1, 5, 0, 2, 1, 0);
    ticks(55);
    expect_st("ring2", 0, 2, 0, 0, 2, 1, 1);
    pulse_stop();
    expect_st("stop_silence", 0, 2, 1, 0, 2, 1, 0);
    pulse_stop();
    expect_st("stop_disarm", 0, 2, 2, 0, 2, 0, 0);

    bus.semnal_setare = 1'b1;
    for (int i = 0; i < 59; i++) pulse_b2();
    bus.semnal_setare = 1'b0;
    expect_st("set_back", 0, 1, 0, 0, 2, 0, 0);
    ticks(60);
    expect_st("disarmed_no_ring", 0, 2, 0, 0, 2, 0, 0);

    bus.semnal_setare_a = 1'b1;
    pulse_b2();
    cyc(2);
    bus.semnal_setare_a = 1'b0;
    cyc(4);
    expect_st("rearm2", 0, 2, 2, 0, 3, 1, 0);
    ticks(58);
    expect_st("ring3", 0, 3, 0, 0, 3, 1, 1);

    bus.semnal_b1 = 1'b1; cyc(1);
    bus.semnal_b1 = 1'b0; cyc(3);
`ifdef CEAS_SNOOZE_EN
    expect_st("snooze_quiet", 0, 3, 1, 0, 3, 1, 0);
    ticks(1);
    expect_st("snooze_rering", 0, 3, 2, 0, 3, 1, 1);
`else
    expect_st("b1_run_ignored", 0, 3, 1, 0, 3, 1, 1);
    ticks(1);
    expect_st("b1_run_hold", 0, 3, 2, 0, 3, 1, 1);
`endif

    // reset while ringing drops the alarm setting as well
    cyc(1);
    reset = 1'b0;
    #1;
    check_now("reset_mid_ring_now", 0, 0, 0, 0, 0, 0, 0);
    expect_st("reset_mid_ring", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(1);

    if (n_pass != n_total)
      $display("FAIL summary: %0d/%0d checks passed", n_pass, n_total);
    else
      $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
